// File: rtl/multi_cycle_alu.sv
// ============================================================================
// multi_cycle_alu : start/done ALU with single-cycle logic/arith/branch ops and
//                   iterative shifts (SHIFT_STEP bits per cycle). Optional SRA
//                   via macro ALU_SRA_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multi_cycle_alu #(
   parameter int DATA_WIDTH = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [4:0]            alu_op_i,
   input  logic [DATA_WIDTH-1:0] in_a_i,
   input  logic [DATA_WIDTH-1:0] in_b_i,
   output logic                  ready_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  bcond_o
);

   localparam int SHW = $clog2(DATA_WIDTH);
   localparam int CW  = SHW + 1;
   localparam logic [CW-1:0] c_STEP = CW'(SHIFT_STEP);

   localparam logic [4:0] c_OP_ADD = 5'b00011;
   localparam logic [4:0] c_OP_SUB = 5'b00100;
   localparam logic [4:0] c_OP_AND = 5'b01001;
   localparam logic [4:0] c_OP_OR  = 5'b01010;
   localparam logic [4:0] c_OP_XOR = 5'b01101;
   localparam logic [4:0] c_OP_SLL = 5'b01111;
   localparam logic [4:0] c_OP_SRL = 5'b10000;
   localparam logic [4:0] c_OP_SRA = 5'b10001;
   localparam logic [4:0] c_OP_BEQ = 5'b10011;
   localparam logic [4:0] c_OP_BNE = 5'b10100;
   localparam logic [4:0] c_OP_BLT = 5'b10101;
   localparam logic [4:0] c_OP_BGE = 5'b10110;

`ifdef ALU_SRA_EN
   localparam logic c_SRA_EN = 1'b1;
`else
   localparam logic c_SRA_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   acc_q, acc_d;
   logic [DATA_WIDTH-1:0]   result_q, result_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    left_q, left_d;
   logic                    arith_q, arith_d;
   logic                    bcond_q, bcond_d;

   logic                    w_accept;
   logic [CW-1:0]           w_shamt;
   logic [DATA_WIDTH-1:0]   w_diff;
   logic                    w_lt;
   logic                    w_is_shift;
   logic                    w_left;
   logic                    w_arith;
   logic [DATA_WIDTH-1:0]   w_res;
   logic                    w_bc;
   logic [CW-1:0]           w_step;
   logic [DATA_WIDTH-1:0]   w_acc_sh;

   assign w_accept = start_i && (state_q != S_SHIFT);
   assign w_shamt  = {1'b0, in_b_i[SHW-1:0]};
   assign w_diff   = in_a_i - in_b_i;
   assign w_lt     = $signed(in_a_i) < $signed(in_b_i);

   // Single-cycle decode; shifts report in_a here, which is the shamt=0 result.
   always_comb begin
      w_is_shift = 1'b0;
      w_left     = 1'b0;
      w_arith    = 1'b0;
      w_res      = '0;
      w_bc       = 1'b0;
      case (alu_op_i)
         c_OP_ADD: w_res = in_a_i + in_b_i;
         c_OP_SUB: w_res = w_diff;
         c_OP_AND: w_res = in_a_i & in_b_i;
         c_OP_OR:  w_res = in_a_i | in_b_i;
         c_OP_XOR: w_res = in_a_i ^ in_b_i;
         c_OP_SLL: begin
            w_is_shift = 1'b1;
            w_left     = 1'b1;
            w_res      = in_a_i;
         end
         c_OP_SRL: begin
            w_is_shift = 1'b1;
            w_res      = in_a_i;
         end
         c_OP_SRA: begin
            if (c_SRA_EN) begin
               w_is_shift = 1'b1;
               w_arith    = 1'b1;
               w_res      = in_a_i;
            end
         end
         c_OP_BEQ: begin
            w_res = w_diff;
            w_bc  = (in_a_i == in_b_i);
         end
         c_OP_BNE: begin
            w_res = w_diff;
            w_bc  = (in_a_i != in_b_i);
         end
         c_OP_BLT: begin
            w_res = w_diff;
            w_bc  = w_lt;
         end
         c_OP_BGE: begin
            w_res = w_diff;
            w_bc  = !w_lt;
         end
         default: ;
      endcase
   end

   assign w_step = (cnt_q < c_STEP) ? cnt_q : c_STEP;

   always_comb begin
      if (left_q) begin
         w_acc_sh = acc_q << w_step;
      end else if (arith_q) begin
         w_acc_sh = DATA_WIDTH'($signed(acc_q) >>> w_step);
      end else begin
         w_acc_sh = acc_q >> w_step;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      left_d   = left_q;
      arith_d  = arith_q;
      result_d = result_q;
      bcond_d  = bcond_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
               if (w_is_shift && (w_shamt != '0)) begin
                  acc_d   = in_a_i;
                  cnt_d   = w_shamt;
                  left_d  = w_left;
                  arith_d = w_arith;
                  state_d = S_SHIFT;
               end else begin
                  result_d = w_res;
                  bcond_d  = w_bc;
                  state_d  = S_DONE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            acc_d = w_acc_sh;
            cnt_d = cnt_q - w_step;
            if (cnt_d == '0) begin
               result_d = w_acc_sh;
               bcond_d  = 1'b0;
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         left_q   <= 1'b0;
         arith_q  <= 1'b0;
         result_q <= '0;
         bcond_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         left_q   <= left_d;
         arith_q  <= arith_d;
         result_q <= result_d;
         bcond_q  <= bcond_d;
      end
   end

   assign ready_o  = (state_q != S_SHIFT);
   assign busy_o   = (state_q == S_SHIFT);
   assign done_o   = (state_q == S_DONE);
   assign result_o = result_q;
   assign bcond_o  = bcond_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_alu.sv
// ============================================================================
// tb_multi_cycle_alu : vector table, random ops against a reference model and
//                      handshake corner sequences on SHIFT_STEP=1 and =4 units.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multi_cycle_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  alu_op;
   logic [31:0] in_a;
   logic [31:0] in_b;

   logic        ready1, busy1, done1, bcond1;
   logic [31:0] result1;
   logic        ready4, busy4, done4, bcond4;
   logic [31:0] result4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   multi_cycle_alu #(.DATA_WIDTH(32), .SHIFT_STEP(1)) u_dut1 (
      .clk_i(clk), .reset_i(reset), .start_i(start), .alu_op_i(alu_op),
      .in_a_i(in_a), .in_b_i(in_b), .ready_o(ready1), .busy_o(busy1),
      .done_o(done1), .result_o(result1), .bcond_o(bcond1)
   );

   multi_cycle_alu #(.DATA_WIDTH(32), .SHIFT_STEP(4)) u_dut4 (
      .clk_i(clk), .reset_i(reset), .start_i(start), .alu_op_i(alu_op),
      .in_a_i(in_a), .in_b_i(in_b), .ready_o(ready4), .busy_o(busy4),
      .done_o(done4), .result_o(result4), .bcond_o(bcond4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic is_shift(input logic [4:0] op);
`ifdef ALU_SRA_EN
      return (op == 5'b01111) || (op == 5'b10000) || (op == 5'b10001);
`else
      return (op == 5'b01111) || (op == 5'b10000);
`endif
   endfunction

   function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic bc);
      int k;
      k  = int'(b[4:0]);
      r  = 32'd0;
      bc = 1'b0;
      case (op)
         5'b00011: r = a + b;
         5'b00100: r = a - b;
         5'b01001: r = a & b;
         5'b01010: r = a | b;
         5'b01101: r = a ^ b;
         5'b01111: r = a << k;
         5'b10000: r = a >> k;
`ifdef ALU_SRA_EN
         5'b10001: r = $signed(a) >>> k;
`endif
         5'b10011: begin r = a - b; bc = (a == b); end
         5'b10100: begin r = a - b; bc = (a != b); end
         5'b10101: begin r = a - b; bc = ($signed(a) < $signed(b)); end
         5'b10110: begin r = a - b; bc = ($signed(a) >= $signed(b)); end
         default: ;
      endcase
   endfunction

   function automatic int model_lat(input logic [4:0] op, input logic [31:0] b, input int step);
      int k;
      k = int'(b[4:0]);
      if (is_shift(op) && k > 0) return 1 + (k + step - 1) / step;
      return 1;
   endfunction

   // Issue one op, then watch both units until each has pulsed done once.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r1, output logic b1, output int l1,
                         output logic [31:0] r4, output logic b4, output int l4);
      start  = 1'b1;
      alu_op = op;
      in_a   = a;
      in_b   = b;
      tick();
      start  = 1'b0;
      alu_op = 5'($urandom);
      in_a   = $urandom;
      in_b   = $urandom;
      r1 = '0; b1 = 1'b0; l1 = -1;
      r4 = '0; b4 = 1'b0; l4 = -1;
      for (int c = 1; c <= 80; c++) begin
         if (done1 && l1 < 0) begin l1 = c; r1 = result1; b1 = bcond1; end
         if (done4 && l4 < 0) begin l4 = c; r4 = result4; b4 = bcond4; end
         if (l1 >= 0 && l4 >= 0) break;
         tick();
      end
   endtask

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        bc;
      int          lat1;
      int          lat4;
   } vec_t;

   vec_t vecs[14];

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] r1, r4, er;
      logic        bb1, bb4, eb;
      int          l1, l4, busy_cnt, done_cnt, done_at;
      logic [4:0]  op;
      logic [31:0] a, b;
      logic [4:0]  op_pool[12];

      vecs[0]  = '{5'b00011, 32'd7, 32'd5, 32'd12, 1'b0, 1, 1};
      vecs[1]  = '{5'b00100, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1, 1};
      vecs[2]  = '{5'b10101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1, 1, 1};
      vecs[3]  = '{5'b10110, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0, 1, 1};
      vecs[4]  = '{5'b10011, 32'd9, 32'd9, 32'd0, 1'b1, 1, 1};
      vecs[5]  = '{5'b10100, 32'd9, 32'd9, 32'd0, 1'b0, 1, 1};
      vecs[6]  = '{5'b01111, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 32, 9};
      vecs[7]  = '{5'b10000, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b0, 1, 1};
`ifdef ALU_SRA_EN
      vecs[8]  = '{5'b10001, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 5, 2};
`else
      vecs[8]  = '{5'b10001, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 1, 1};
`endif
      vecs[9]  = '{5'b01001, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1, 1};
      vecs[10] = '{5'b01010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0, 1, 1};
      vecs[11] = '{5'b01101, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1'b0, 1, 1};
      vecs[12] = '{5'b10000, 32'h8000_0000, 32'd33, 32'h4000_0000, 1'b0, 2, 2};
      vecs[13] = '{5'b11111, 32'd77, 32'd77, 32'd0, 1'b0, 1, 1};

      op_pool = '{5'b00011, 5'b00100, 5'b01001, 5'b01010, 5'b01101, 5'b01111,
                  5'b10000, 5'b10001, 5'b10011, 5'b10100, 5'b10101, 5'b10110};

      alu_op = '0;
      in_a   = '0;
      in_b   = '0;
      do_reset();

      chk("reset ready1", 32'(ready1), 32'd1);
      chk("reset busy1", 32'(busy1), 32'd0);
      chk("reset done1", 32'(done1), 32'd0);
      chk("reset result1", result1, 32'd0);
      chk("reset bcond1", 32'(bcond1), 32'd0);
      chk("reset ready4", 32'(ready4), 32'd1);
      chk("reset busy4", 32'(busy4), 32'd0);

      for (int i = 0; i < 14; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, r1, bb1, l1, r4, bb4, l4);
         chk($sformatf("vec%0d res1", i), r1, vecs[i].res);
         chk($sformatf("vec%0d bc1", i), 32'(bb1), 32'(vecs[i].bc));
         chk($sformatf("vec%0d lat1", i), 32'(l1), 32'(vecs[i].lat1));
         chk($sformatf("vec%0d res4", i), r4, vecs[i].res);
         chk($sformatf("vec%0d bc4", i), 32'(bb4), 32'(vecs[i].bc));
         chk($sformatf("vec%0d lat4", i), 32'(l4), 32'(vecs[i].lat4));
         tick();
      end

      for (int i = 0; i < 150; i++) begin
         op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : op_pool[$urandom_range(0, 11)];
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
         if ($urandom_range(0, 3) == 0) a = {a[31], 31'($urandom_range(0, 3))};
         model(op, a, b, er, eb);
         run_op(op, a, b, r1, bb1, l1, r4, bb4, l4);
         chk($sformatf("rnd%0d op%b res1", i, op), r1, er);
         chk($sformatf("rnd%0d op%b bc1", i, op), 32'(bb1), 32'(eb));
         chk($sformatf("rnd%0d op%b lat1", i, op), 32'(l1), 32'(model_lat(op, b, 1)));
         chk($sformatf("rnd%0d op%b res4", i, op), r4, er);
         chk($sformatf("rnd%0d op%b lat4", i, op), 32'(l4), 32'(model_lat(op, b, 4)));
         if ($urandom_range(0, 1) == 1) tick();
      end

      // Start pulses while busy must be ignored.
      do_reset();
      start = 1'b1; alu_op = 5'b01111; in_a = 32'd1; in_b = 32'd31;
      tick();
      start = 1'b0;
      busy_cnt = 0; done_cnt = 0; done_at = -1;
      for (int c = 1; c <= 45; c++) begin
         if (busy1) busy_cnt++;
         if (done1) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
         end
         start  = busy1 && (c % 3 == 0);
         alu_op = 5'b00011; in_a = 32'd100; in_b = 32'd200;
         tick();
      end
      start = 1'b0;
      chk("busy-ignore busy cycles", 32'(busy_cnt), 32'd31);
      chk("busy-ignore done count", 32'(done_cnt), 32'd1);
      chk("busy-ignore done cycle", 32'(done_at), 32'd32);
      chk("busy-ignore result", result1, 32'h8000_0000);

      // Reset in the middle of a shift aborts it.
      do_reset();
      start = 1'b1; alu_op = 5'b01111; in_a = 32'd1; in_b = 32'd31;
      tick();
      start = 1'b0;
      repeat (5) tick();
      chk("mid-shift busy", 32'(busy1), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort ready", 32'(ready1), 32'd1);
      chk("abort busy", 32'(busy1), 32'd0);
      chk("abort done", 32'(done1), 32'd0);
      chk("abort result", result1, 32'd0);
      done_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         if (done1) done_cnt++;
         tick();
      end
      chk("abort no done", 32'(done_cnt), 32'd0);

      // Back-to-back: start held high in the DONE cycle.
      start = 1'b1; alu_op = 5'b00011; in_a = 32'd7; in_b = 32'd5;
      tick();
      chk("b2b first done", 32'(done1), 32'd1);
      chk("b2b first result", result1, 32'd12);
      alu_op = 5'b00100; in_a = 32'd3; in_b = 32'd5;
      tick();
      start = 1'b0;
      chk("b2b second done", 32'(done1), 32'd1);
      chk("b2b second result", result1, 32'hFFFF_FFFE);
      tick();
      chk("b2b idle done", 32'(done1), 32'd0);
      chk("b2b result held", result1, 32'hFFFF_FFFE);

      // Reset and start on the same edge: start dropped.
      reset = 1'b1; start = 1'b1; alu_op = 5'b00011; in_a = 32'd7; in_b = 32'd5;
      tick();
      reset = 1'b0; start = 1'b0;
      chk("rst+start done", 32'(done1), 32'd0);
      chk("rst+start result", result1, 32'd0);
      tick();
      chk("rst+start later done", 32'(done1), 32'd0);
      chk("rst+start ready", 32'(ready1), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
